// File: rtl/audio_fir_coeff_regs.sv
// AXI4-Lite register block for an audio FIR: control/status, shadow coefficient bank,
// and a frame-synchronous shadow-to-active commit so taps never change mid-sample.
module audio_fir_coeff_regs #(
    parameter int NUM_TAPS    = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int ADDR_WIDTH  = 9
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [ADDR_WIDTH-1:0]           s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [31:0]                     s_axi_wdata,
    input  logic [3:0]                      s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]           s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [31:0]                     s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    input  logic                            frame_sync,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff_flat,
    output logic                            fir_enable,
    output logic                            fir_bypass,
    output logic                            commit_done
);

    localparam logic [31:0] ID_VALUE        = 32'hF1C0_0002;
    localparam int          COEFF_BASE_WORD = 32'h40;
    localparam logic [1:0]  RESP_OKAY       = 2'b00;
    localparam logic [1:0]  RESP_SLVERR     = 2'b10;

    logic                   rdy_en_reg;
    logic                   aw_full_reg;
    logic [ADDR_WIDTH-1:0]  aw_addr_reg;
    logic                   w_full_reg;
    logic [31:0]            w_data_reg;
    logic [3:0]             w_strb_reg;
    logic                   bvalid_reg;
    logic [1:0]             bresp_reg;
    logic                   rvalid_reg;
    logic [31:0]            rdata_reg;
    logic [1:0]             rresp_reg;
    logic                   ctrl_enable_reg;
    logic                   ctrl_bypass_reg;
    logic                   commit_pending_reg;
    logic                   commit_done_reg;

    logic [COEFF_WIDTH-1:0] shadow_reg [NUM_TAPS];
    logic [COEFF_WIDTH-1:0] active_reg [NUM_TAPS];

    logic [31:0]            wr_word;
    logic [31:0]            rd_word;
    logic [NUM_TAPS-1:0]    wr_tap_hit;
    logic [NUM_TAPS-1:0]    rd_tap_hit;
    logic                   wr_is_ctrl;
    logic                   wr_err;
    logic                   do_write;
    logic                   commit_req;
    logic                   commit_fire;
    logic [31:0]            rd_data;
    logic                   rd_err;
    logic [COEFF_WIDTH-1:0] rd_coeff;

    function automatic logic [COEFF_WIDTH-1:0] merge_coeff(
        input logic [COEFF_WIDTH-1:0] old_val,
        input logic [31:0]            data,
        input logic [3:0]             strb
    );
        logic [31:0] full;
        full = 32'(old_val);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) full[b*8 +: 8] = data[b*8 +: 8];
        end
        return full[COEFF_WIDTH-1:0];
    endfunction

    function automatic logic [31:0] sign_extend(input logic [COEFF_WIDTH-1:0] v);
        logic [31:0] full;
        full = 32'(v);
        for (int i = COEFF_WIDTH; i < 32; i++) full[i] = v[COEFF_WIDTH-1];
        return full;
    endfunction

    // Ready outputs are gated by rdy_en_reg so they stay low during reset and rise on the first edge after it.
    assign s_axi_awready = rdy_en_reg & ~aw_full_reg & ~bvalid_reg;
    assign s_axi_wready  = rdy_en_reg & ~w_full_reg & ~bvalid_reg;
    assign s_axi_arready = rdy_en_reg & ~rvalid_reg;
    assign s_axi_bvalid  = bvalid_reg;
    assign s_axi_bresp   = bresp_reg;
    assign s_axi_rvalid  = rvalid_reg;
    assign s_axi_rdata   = rdata_reg;
    assign s_axi_rresp   = rresp_reg;
    assign fir_enable    = ctrl_enable_reg;
    assign fir_bypass    = ctrl_bypass_reg;
    assign commit_done   = commit_done_reg;

    assign wr_word     = 32'(aw_addr_reg) >> 2;
    assign rd_word     = 32'(s_axi_araddr) >> 2;
    assign do_write    = aw_full_reg & w_full_reg;
    assign wr_is_ctrl  = (wr_word == 32'd0);
    assign wr_err      = ~(wr_is_ctrl | (|wr_tap_hit));
    assign commit_req  = do_write & wr_is_ctrl & w_strb_reg[0] & w_data_reg[1];
    assign commit_fire = commit_pending_reg & frame_sync;

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
            assign wr_tap_hit[gi] = (wr_word == 32'(COEFF_BASE_WORD + gi));
            assign rd_tap_hit[gi] = (rd_word == 32'(COEFF_BASE_WORD + gi));
            assign coeff_flat[gi*COEFF_WIDTH +: COEFF_WIDTH] = active_reg[gi];
        end
    endgenerate

    always_comb begin
        rd_data  = '0;
        rd_err   = 1'b0;
        rd_coeff = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (rd_tap_hit[i]) rd_coeff = shadow_reg[i];
        end
        if (rd_word == 32'd0) begin
            rd_data = {29'd0, ctrl_bypass_reg, 1'b0, ctrl_enable_reg};
        end else if (rd_word == 32'd1) begin
            rd_data = {8'h00, 8'(COEFF_WIDTH), 8'(NUM_TAPS), 7'd0, commit_pending_reg};
        end else if (rd_word == 32'd2) begin
            rd_data = ID_VALUE;
        end else if (|rd_tap_hit) begin
            rd_data = sign_extend(rd_coeff);
        end else begin
            rd_err = 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rdy_en_reg  <= 1'b0;
            aw_full_reg <= 1'b0;
            aw_addr_reg <= '0;
            w_full_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            rdy_en_reg <= 1'b1;
            if (s_axi_awvalid && s_axi_awready) begin
                aw_full_reg <= 1'b1;
                aw_addr_reg <= s_axi_awaddr;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_full_reg <= 1'b1;
                w_data_reg <= s_axi_wdata;
                w_strb_reg <= s_axi_wstrb;
            end
            if (do_write) begin
                aw_full_reg <= 1'b0;
                w_full_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_reg && s_axi_bready) begin
                bvalid_reg <= 1'b0;
            end
            if (s_axi_arvalid && s_axi_arready) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_data;
                rresp_reg  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid_reg && s_axi_rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    // A commit request landing in the same cycle as a copy re-arms pending for the next frame.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ctrl_enable_reg    <= 1'b0;
            ctrl_bypass_reg    <= 1'b0;
            commit_pending_reg <= 1'b0;
            commit_done_reg    <= 1'b0;
        end else begin
            commit_done_reg <= commit_fire;
            if (commit_req) begin
                commit_pending_reg <= 1'b1;
            end else if (commit_fire) begin
                commit_pending_reg <= 1'b0;
            end
            if (do_write && wr_is_ctrl && w_strb_reg[0]) begin
                ctrl_enable_reg <= w_data_reg[0];
                ctrl_bypass_reg <= w_data_reg[2];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (do_write && wr_tap_hit[i]) begin
                    shadow_reg[i] <= merge_coeff(shadow_reg[i], w_data_reg, w_strb_reg);
                end
                if (commit_fire) begin
                    active_reg[i] <= shadow_reg[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_fir_coeff_regs.sv
// Directed bench for audio_fir_coeff_regs: register-map vector table plus hand-written
// sequences for commit timing, split AW/W with back-pressure, and reset mid-transaction.
module tb_audio_fir_coeff_regs;

    localparam int NT = 16;
    localparam int CW = 16;
    localparam int AW = 9;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [AW-1:0]     s_axi_awaddr = '0;
    logic              s_axi_awvalid = 1'b0;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata = '0;
    logic [3:0]        s_axi_wstrb = '0;
    logic              s_axi_wvalid = 1'b0;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready = 1'b0;
    logic [AW-1:0]     s_axi_araddr = '0;
    logic              s_axi_arvalid = 1'b0;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready = 1'b0;
    logic              frame_sync = 1'b0;
    logic [NT*CW-1:0]  coeff_flat;
    logic              fir_enable;
    logic              fir_bypass;
    logic              commit_done;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 ACLK = ~ACLK;

    audio_fir_coeff_regs #(.NUM_TAPS(NT), .COEFF_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .frame_sync(frame_sync),
        .coeff_flat(coeff_flat), .fir_enable(fir_enable), .fir_bypass(fir_bypass),
        .commit_done(commit_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        logic aw_hs, w_hs, aw_done, w_done;
        @(negedge ACLK);
        s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        s_axi_bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = s_axi_awvalid & s_axi_awready;
            w_hs  = s_axi_wvalid & s_axi_wready;
            @(posedge ACLK); #1;
            if (aw_hs) begin s_axi_awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin s_axi_wvalid = 1'b0;  w_done = 1'b1;  end
            @(negedge ACLK);
            n++;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(negedge ACLK); n++; end
        chk("wr_handshake_done", {31'd0, aw_done & w_done & s_axi_bvalid}, 32'd1);
        resp = s_axi_bresp;
        if (s_axi_bvalid) begin @(posedge ACLK); #1; end
        s_axi_bready = 1'b0;
        $display("write addr=0x%03h data=0x%08h strb=0x%h bresp=%0d", addr, data, strb, resp);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        logic ar_hs, ar_done;
        @(negedge ACLK);
        s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        ar_done = 1'b0; n = 0;
        while (!ar_done && n < 20) begin
            ar_hs = s_axi_arvalid & s_axi_arready;
            @(posedge ACLK); #1;
            if (ar_hs) begin s_axi_arvalid = 1'b0; ar_done = 1'b1; end
            @(negedge ACLK);
            n++;
        end
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 20) begin @(negedge ACLK); n++; end
        chk("rd_handshake_done", {31'd0, ar_done & s_axi_rvalid}, 32'd1);
        data = s_axi_rdata; resp = s_axi_rresp;
        if (s_axi_rvalid) begin @(posedge ACLK); #1; end
        s_axi_rready = 1'b0;
        $display("read  addr=0x%03h rdata=0x%08h rresp=%0d", addr, data, resp);
    endtask

    task automatic pulse_frame_sync(output logic done_during, output logic done_after, output logic done_later);
        @(negedge ACLK);
        frame_sync = 1'b1;
        done_during = commit_done;
        @(negedge ACLK);
        frame_sync = 1'b0;
        done_after = commit_done;
        @(negedge ACLK);
        done_later = commit_done;
    endtask

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    strb;
        logic [1:0]    resp;
        logic [31:0]   rdata;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        logic        d0, d1, d2, ok;
        int          n;

        vecs[0]  = '{1'b1, 9'h100, 32'h0000_1234, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 9'h100, 32'h0,         4'h0, 2'b00, 32'h0000_1234};
        vecs[2]  = '{1'b1, 9'h108, 32'hFFFF_FFFF, 4'h1, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 9'h108, 32'h0,         4'h0, 2'b00, 32'h0000_00FF};
        vecs[4]  = '{1'b1, 9'h004, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
        vecs[5]  = '{1'b0, 9'h0F0, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[6]  = '{1'b0, 9'h004, 32'h0,         4'h0, 2'b00, 32'h0010_1000};
        vecs[7]  = '{1'b0, 9'h008, 32'h0,         4'h0, 2'b00, 32'hF1C0_0002};
        vecs[8]  = '{1'b1, 9'h008, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0};
        vecs[9]  = '{1'b0, 9'h008, 32'h0,         4'h0, 2'b00, 32'hF1C0_0002};
        vecs[10] = '{1'b1, 9'h000, 32'h0000_0005, 4'hF, 2'b00, 32'h0};
        vecs[11] = '{1'b0, 9'h000, 32'h0,         4'h0, 2'b00, 32'h0000_0005};
        vecs[12] = '{1'b1, 9'h13C, 32'h0000_ABCD, 4'hF, 2'b00, 32'h0};
        vecs[13] = '{1'b0, 9'h13C, 32'h0,         4'h0, 2'b00, 32'hFFFF_ABCD};
        vecs[14] = '{1'b1, 9'h140, 32'h0000_1111, 4'hF, 2'b10, 32'h0};
        vecs[15] = '{1'b0, 9'h140, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[16] = '{1'b1, 9'h104, 32'h1234_5678, 4'h2, 2'b00, 32'h0};
        vecs[17] = '{1'b0, 9'h104, 32'h0,         4'h0, 2'b00, 32'h0000_5600};
        vecs[18] = '{1'b0, 9'h004, 32'h0,         4'h0, 2'b00, 32'h0010_1000};

        // Reset state, including readies held low while ARESET is high.
        repeat (3) @(negedge ACLK);
        chk("rst_awready", s_axi_awready, 0);
        chk("rst_wready", s_axi_wready, 0);
        chk("rst_arready", s_axi_arready, 0);
        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_rdata", s_axi_rdata, 0);
        chk("rst_coeff_nonzero", {31'd0, |coeff_flat}, 0);
        chk("rst_enable", fir_enable, 0);
        chk("rst_commit_done", commit_done, 0);
        ARESET = 1'b0;
        #1 chk("rel_awready_before_edge", s_axi_awready, 0);
        @(negedge ACLK);
        chk("rel_awready", s_axi_awready, 1);
        chk("rel_wready", s_axi_wready, 1);
        chk("rel_arready", s_axi_arready, 1);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
                chk($sformatf("vec%0d_bresp", i), rsp, vecs[i].resp);
            end else begin
                axi_read(vecs[i].addr, rd, rsp);
                chk($sformatf("vec%0d_rresp", i), rsp, vecs[i].resp);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            end
        end
        chk("tbl_coeff_untouched", {31'd0, |coeff_flat}, 0);
        chk("tbl_enable", fir_enable, 1);
        chk("tbl_bypass", fir_bypass, 1);

        // Commit: shadow tap1 = 0x8001, then CTRL enable+commit, copy on next frame_sync.
        axi_write(9'h104, 32'h0000_8001, 4'hF, rsp);
        axi_write(9'h000, 32'h0000_0003, 4'hF, rsp);
        axi_read(9'h004, rd, rsp);
        chk("cm_status_pending", rd, 32'h0010_1001);
        chk("cm_coeff_before", {31'd0, |coeff_flat}, 0);
        pulse_frame_sync(d0, d1, d2);
        chk("cm_done_during_fs", d0, 0);
        chk("cm_done_next_cycle", d1, 1);
        chk("cm_done_one_cycle", d2, 0);
        chk("cm_tap0", coeff_flat[15:0], 32'h1234);
        chk("cm_tap1", coeff_flat[31:16], 32'h8001);
        chk("cm_tap2", coeff_flat[47:32], 32'h00FF);
        chk("cm_tap15", coeff_flat[255:240], 32'hABCD);
        axi_read(9'h104, rd, rsp);
        chk("cm_rd_tap1_sext", rd, 32'hFFFF_8001);
        axi_read(9'h004, rd, rsp);
        chk("cm_status_clear", rd, 32'h0010_1000);
        axi_read(9'h000, rd, rsp);
        chk("cm_ctrl_bit1_reads0", rd, 32'h0000_0001);
        chk("cm_bypass_off", fir_bypass, 0);

        // frame_sync with nothing pending leaves the active bank alone.
        axi_write(9'h100, 32'h0000_7777, 4'hF, rsp);
        pulse_frame_sync(d0, d1, d2);
        chk("idle_fs_done", {29'd0, d0, d1, d2}, 0);
        chk("idle_fs_tap0", coeff_flat[15:0], 32'h1234);

        // Double commit and a shadow write while pending collapse into one copy.
        axi_write(9'h000, 32'h0000_0003, 4'hF, rsp);
        axi_write(9'h100, 32'h0000_0101, 4'hF, rsp);
        axi_write(9'h000, 32'h0000_0003, 4'hF, rsp);
        chk("dbl_tap0_before", coeff_flat[15:0], 32'h1234);
        pulse_frame_sync(d0, d1, d2);
        chk("dbl_done", {29'd0, d0, d1, d2}, 32'b010);
        chk("dbl_tap0", coeff_flat[15:0], 32'h0101);
        pulse_frame_sync(d0, d1, d2);
        chk("dbl_single_copy", {29'd0, d0, d1, d2}, 0);

        // W leads AW by 3 cycles; bready held low for 5 cycles.
        @(negedge ACLK);
        chk("sp_wready", s_axi_wready, 1);
        s_axi_wdata = 32'h0000_2222; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        @(posedge ACLK); #1 s_axi_wvalid = 1'b0;
        repeat (2) begin
            @(negedge ACLK);
            chk("sp_no_early_bvalid", s_axi_bvalid, 0);
            chk("sp_wready_low", s_axi_wready, 0);
        end
        @(negedge ACLK);
        chk("sp_awready", s_axi_awready, 1);
        s_axi_awaddr = 9'h10C; s_axi_awvalid = 1'b1;
        @(posedge ACLK); #1 s_axi_awvalid = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (!s_axi_bvalid && n < 10) begin @(negedge ACLK); n++; end
        chk("sp_bvalid", s_axi_bvalid, 1);
        chk("sp_bresp", s_axi_bresp, 0);
        ok = 1'b1;
        repeat (5) begin
            @(negedge ACLK);
            if (!s_axi_bvalid || s_axi_bresp != 2'b00 || s_axi_awready || s_axi_wready) ok = 1'b0;
        end
        chk("sp_bvalid_held", ok, 1);
        s_axi_bready = 1'b1;
        @(posedge ACLK); #1 s_axi_bready = 1'b0;
        @(negedge ACLK);
        chk("sp_bvalid_dropped", s_axi_bvalid, 0);
        axi_read(9'h10C, rd, rsp);
        chk("sp_rd_tap3", rd, 32'h0000_2222);

        // Reset while a commit is pending and a write response is outstanding.
        axi_write(9'h000, 32'h0000_0002, 4'hF, rsp);
        chk("rs_enable_off", fir_enable, 0);
        @(negedge ACLK);
        chk("rs_awready", s_axi_awready, 1);
        s_axi_awaddr = 9'h100; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h0000_5555; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        @(posedge ACLK); #1 s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (!s_axi_bvalid && n < 10) begin @(negedge ACLK); n++; end
        chk("rs_bvalid_before", s_axi_bvalid, 1);
        ARESET = 1'b1;
        #1;
        chk("rs_bvalid", s_axi_bvalid, 0);
        chk("rs_coeff_nonzero", {31'd0, |coeff_flat}, 0);
        chk("rs_awready", s_axi_awready, 0);
        chk("rs_arready", s_axi_arready, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("rs_awready_back", s_axi_awready, 1);
        pulse_frame_sync(d0, d1, d2);
        chk("rs_no_commit", {29'd0, d0, d1, d2}, 0);
        chk("rs_coeff_still_zero", {31'd0, |coeff_flat}, 0);
        axi_read(9'h004, rd, rsp);
        chk("rs_status", rd, 32'h0010_1000);
        axi_read(9'h100, rd, rsp);
        chk("rs_shadow_cleared", rd, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/audio_fir_coeff_regs.md
AUDIO_FIR_COEFF_REGS -- requirements
Module: audio_fir_coeff_regs

Interface
REQ-001 Parameter NUM_TAPS, default 16: number of FIR coefficient registers (1..64).
REQ-002 Parameter COEFF_WIDTH, default 16: stored bits per coefficient (2..32).
REQ-003 Parameter ADDR_WIDTH, default 9: AXI4-Lite byte address width (2^ADDR_WIDTH >= 0x100 + 4*NUM_TAPS).
REQ-004 ACLK  in  1  sole clock; all logic rising-edge.
REQ-005 ARESET  in  1  asynchronous, active-high reset.
REQ-006 s_axi_awaddr  in  ADDR_WIDTH  write address.
REQ-007 s_axi_awvalid  in  1  write address valid.
REQ-008 s_axi_awready  out  1  write address ready.
REQ-009 s_axi_wdata  in  32  write data.
REQ-010 s_axi_wstrb  in  4  byte strobes.
REQ-011 s_axi_wvalid  in  1  write data valid.
REQ-012 s_axi_wready  out  1  write data ready.
REQ-013 s_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR).
REQ-014 s_axi_bvalid  out  1  write response valid.
REQ-015 s_axi_bready  in  1  write response ready.
REQ-016 s_axi_araddr  in  ADDR_WIDTH  read address.
REQ-017 s_axi_arvalid  in  1  read address valid.
REQ-018 s_axi_arready  out  1  read address ready.
REQ-019 s_axi_rdata  out  32  read data.
REQ-020 s_axi_rresp  out  2  read response.
REQ-021 s_axi_rvalid  out  1  read data valid.
REQ-022 s_axi_rready  in  1  read data ready.
REQ-023 frame_sync  in  1  one-cycle pulse at each audio sample boundary.
REQ-024 coeff_flat  out  NUM_TAPS*COEFF_WIDTH  active coefficient bank, tap k at bits [k*COEFF_WIDTH +: COEFF_WIDTH].
REQ-025 fir_enable  out  1  CTRL.bit0.
REQ-026 fir_bypass  out  1  CTRL.bit2.
REQ-027 commit_done  out  1  one-cycle pulse when shadow bank is copied to active bank.

Function
REQ-028 Register map SHALL be: 0x000 CTRL RW (bit0 enable, bit1 commit W1S self-clearing, bit2 bypass); 0x004 STATUS RO (bit0 commit_pending, [15:8] NUM_TAPS, [23:16] COEFF_WIDTH); 0x008 ID RO 0xF1C0_0002; 0x100+4k shadow coefficient k, k < NUM_TAPS.
REQ-029 Write channel SHALL accept AW and W independently (each ready high when its holding register is empty and bvalid low), perform the write in the cycle both are held, and assert bvalid the next cycle, holding it and bresp until bready; one write outstanding.
REQ-030 Read channel SHALL assert arready when rvalid is low, register rdata/rresp one cycle after the AR handshake, and hold rvalid until rready; one read outstanding.
REQ-031 Writes SHALL honour wstrb per byte; coefficient registers store wdata[COEFF_WIDTH-1:0] only and read back sign-extended to 32 bits.
REQ-032 Unmapped address or write to a RO register SHALL return SLVERR with no state change; unmapped reads return 0x0000_0000.
REQ-033 Writing CTRL bit1 = 1 SHALL set commit_pending; the shadow-to-active copy SHALL occur on the first frame_sync strictly after the cycle in which commit_pending was set, then clear commit_pending and pulse commit_done for one cycle.
REQ-034 Commit while already pending SHALL remain pending (single copy); shadow writes while pending SHALL be included in that copy.
REQ-035 frame_sync with commit_pending low SHALL have no effect; coeff_flat SHALL change only on a commit copy.
REQ-036 Read of CTRL SHALL return bit1 as 0.

Reset
REQ-037 ARESET high SHALL immediately clear all ready/valid outputs, bresp, rresp, rdata, CTRL, commit_pending, commit_done, shadow and active banks (coeff_flat = 0); transactions in flight are discarded; after release awready/wready/arready rise on the first ACLK edge.

Verification
REQ-038 Write 0x0000_1234 to 0x100, read 0x100 -> rdata 0x0000_1234, OKAY; coeff_flat[15:0] still 0.
REQ-039 Write 0x8001 to 0x104, CTRL = 0x3, pulse frame_sync -> commit_done one cycle later, coeff_flat[31:16] = 0x8001, read 0x104 = 0xFFFF_8001, STATUS bit0 = 0.
REQ-040 Write 0xFFFF_FFFF with wstrb 0x1 to 0x108 after reset -> read 0x0000_00FF.
REQ-041 Write to 0x004 and read 0x0F0 -> both SLVERR, read data 0, STATUS unchanged.
REQ-042 W presented 3 cycles before AW, bready held low 5 cycles -> single write, bvalid held stable until bready.
REQ-043 Assert ARESET while commit pending and bvalid high -> bvalid 0, coeff_flat 0, no commit_done on later frame_sync.
